// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM monitor.
//   pwm_mon_state_t : monitor FSM states
//   PWM_CBITS       : default generator counter width (nominal period 2**CBITS)
//   SW_HI_OFS/LO_OFS: switch-code slice offsets. The generator encodes the duty
//                     as (2*sw+1) << (CBITS-5), so sw sits in bits
//                     [CBITS-2:CBITS-4] of the high time.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_mon_state_t;

  localparam int PWM_CBITS = 19;

  localparam int SW_HI_OFS = 2;
  localparam int SW_LO_OFS = 4;

endpackage

// File: rtl/pwm_monitor_sat_run_counter.sv
// sat_run_counter: saturating up-counter with clear and load-1 controls.
// Ports:
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   clr      : clear to 0 (highest priority after reset)
//   load1    : load the value 1
//   inc      : increment by one, holding at all-ones
//   cnt      : current count
module sat_run_counter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= W'(1);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pwm_monitor.sv
// pwm_monitor: measures high time and period of each complete PWM cycle on
// pulse_in, recovers the 3-bit switch code, and flags a pulse stuck high/low.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   pulse_in    : PWM pulse, same clock domain
//   high_cnt    : high time of the last complete period (cycles)
//   period_cnt  : length of the last complete period (cycles)
//   sw_est      : recovered switch code
//   meas_valid  : result strobe
//   stuck_hi/lo : pulse currently high/low for at least STUCK_LIMIT samples
// Handshake: meas_valid is a one-cycle strobe with no ready/backpressure;
// high_cnt, period_cnt and sw_est change only in the cycle meas_valid is 1
// and hold their value otherwise.
module pwm_monitor
  import pwm_pkg::*;
#(
  parameter int CBITS       = PWM_CBITS,
  parameter int STUCK_LIMIT = 2**CBITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pulse_in,
  output logic [CBITS:0] high_cnt,
  output logic [CBITS:0] period_cnt,
  output logic [2:0]     sw_est,
  output logic           meas_valid,
  output logic           stuck_hi,
  output logic           stuck_lo
);

  localparam logic [CBITS:0] LIM_M1 = (CBITS+1)'(STUCK_LIMIT - 1);

  logic           pulse_q;
  logic           rise;
  logic           fall;
  logic [CBITS:0] hrun;
  logic [CBITS:0] lrun;
  logic [CBITS:0] pcnt;
  logic [CBITS:0] hold_h;
  logic           latch_h;
  logic           fire_meas;
  logic           hi_hit;
  logic           lo_hit;

  pwm_mon_state_t state_q;
  pwm_mon_state_t state_d;

  // pulse_q resets to 1 so a pulse already high at reset is not a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= 1'b1;
    end else begin
      pulse_q <= pulse_in;
    end
  end

  assign rise = pulse_in & ~pulse_q;
  assign fall = ~pulse_in & pulse_q;

  sat_run_counter #(.W(CBITS+1)) u_hrun (
    .clk   (clk),
    .rst   (rst),
    .clr   (~pulse_in),
    .load1 (rise),
    .inc   (pulse_in),
    .cnt   (hrun)
  );

  sat_run_counter #(.W(CBITS+1)) u_lrun (
    .clk   (clk),
    .rst   (rst),
    .clr   (pulse_in),
    .load1 (fall),
    .inc   (~pulse_in),
    .cnt   (lrun)
  );

  sat_run_counter #(.W(CBITS+1)) u_pcnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .load1 (rise),
    .inc   (1'b1),
    .cnt   (pcnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_h   = 1'b0;
    fire_meas = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          latch_h = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          fire_meas = 1'b1;
          state_d   = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // hrun still holds the full high count on the fall edge (cleared after it).
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_h <= '0;
    end else if (latch_h) begin
      hold_h <= hrun;
    end
  end

  // pcnt still holds the full period on the rise edge (reloaded after it).
  always_ff @(posedge clk) begin
    if (rst) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      sw_est     <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= fire_meas;
      if (fire_meas) begin
        high_cnt   <= hold_h;
        period_cnt <= pcnt;
        sw_est     <= hold_h[CBITS-SW_HI_OFS:CBITS-SW_LO_OFS];
      end
    end
  end

  // The run counter steps to STUCK_LIMIT on this edge when it currently holds
  // STUCK_LIMIT-1 and is incrementing (not reloading on an edge).
  assign hi_hit = pulse_in & ~rise & (hrun == LIM_M1);
  assign lo_hit = ~pulse_in & ~fall & (lrun == LIM_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else begin
      if (!pulse_in) begin
        stuck_hi <= 1'b0;
      end else if (hi_hit) begin
        stuck_hi <= 1'b1;
      end
      if (pulse_in) begin
        stuck_lo <= 1'b0;
      end else if (lo_hit) begin
        stuck_lo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_monitor.sv
module tb_pwm_monitor;
  import pwm_pkg::*;

  localparam int CBITS = 8;
  localparam int LIM   = 256;

  logic           clk;
  logic           rst;
  logic           pulse_in;
  logic [CBITS:0] high_cnt;
  logic [CBITS:0] period_cnt;
  logic [2:0]     sw_est;
  logic           meas_valid;
  logic           stuck_hi;
  logic           stuck_lo;

  int n_vec;
  int n_err;

  pwm_monitor #(.CBITS(CBITS), .STUCK_LIMIT(LIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .sw_est     (sw_est),
    .meas_valid (meas_valid),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one sample: drive pulse_in, let one posedge take it, look 1 time unit later
  task automatic tick(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_high_cnt"},   high_cnt,   0);
    chk({tag, "_period_cnt"}, period_cnt, 0);
    chk({tag, "_sw_est"},     sw_est,     0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_stuck_hi"},   stuck_hi,   0);
    chk({tag, "_stuck_lo"},   stuck_lo,   0);
    chk({tag, "_state"},      dut.state_q, IDLE);
  endtask

  // One PWM cycle starting with its rise: h high samples, p total samples.
  // The strobe at the rise reports the previous cycle (eh/ep/esw).
  task automatic pwm_cycle(input int h, input int p, input logic exp_mv,
                           input int eh, input int ep, input int esw);
    int strobes;
    int stucks;
    strobes = 0;
    stucks  = 0;
    tick(1'b1);
    chk("rise_meas_valid", meas_valid, exp_mv);
    chk("rise_stuck_lo_clear", stuck_lo, 0);
    if (exp_mv) begin
      chk("high_cnt",   high_cnt,   eh);
      chk("period_cnt", period_cnt, ep);
      chk("sw_est",     sw_est,     esw);
    end
    for (int i = 1; i < p; i++) begin
      tick(i < h);
      strobes += int'(meas_valid);
      stucks  += int'(stuck_hi) + int'(stuck_lo);
    end
    chk("no_extra_strobe", strobes, 0);
    chk("no_stuck_in_cycle", stucks, 0);
    if (exp_mv) begin
      chk("high_cnt_hold",   high_cnt,   eh);
      chk("period_cnt_hold", period_cnt, ep);
    end
  endtask

  initial begin
    int strobes;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    pulse_in = 1'b0;

    // reset state
    tick(1'b0);
    tick(1'b0);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // pulse low after reset: stuck_lo on the 256th low sample
    for (int i = 0; i < 255; i++) tick(1'b0);
    chk("stuck_lo_before_limit", stuck_lo, 0);
    tick(1'b0);
    chk("stuck_lo_at_limit", stuck_lo, 1);
    chk("no_meas_while_low", meas_valid, 0);

    // first rise clears stuck_lo, no measurement; sw=101 steady
    pwm_cycle(88, 256, 1'b0, 0, 0, 0);
    pwm_cycle(88, 256, 1'b1, 88, 256, 5);
    pwm_cycle(88, 256, 1'b1, 88, 256, 5);
    // switch sw=000 then sw=111 at period boundaries
    pwm_cycle(8,   256, 1'b1, 88,  256, 5);
    pwm_cycle(120, 256, 1'b1, 8,   256, 0);
    pwm_cycle(120, 256, 1'b1, 120, 256, 7);

    // stuck high: rise reports the last 120-cycle period, then hold 300 high
    tick(1'b1);
    chk("hold_rise_meas_valid", meas_valid, 1);
    chk("hold_rise_high_cnt", high_cnt, 120);
    strobes = 0;
    for (int i = 0; i < 254; i++) begin
      tick(1'b1);
      strobes += int'(meas_valid);
    end
    chk("stuck_hi_before_limit", stuck_hi, 0);
    tick(1'b1);
    chk("stuck_hi_at_limit", stuck_hi, 1);
    for (int i = 0; i < 44; i++) begin
      tick(1'b1);
      strobes += int'(meas_valid);
    end
    chk("stuck_hi_held", stuck_hi, 1);
    chk("no_meas_during_hold", strobes, 0);
    tick(1'b0);
    chk("stuck_hi_clear", stuck_hi, 0);
    for (int i = 1; i < 100; i++) tick(1'b0);
    // 300 high (0b100101100 -> sw bits 010), period 400
    tick(1'b1);
    chk("long_meas_valid", meas_valid, 1);
    chk("long_high_cnt",   high_cnt,   300);
    chk("long_period_cnt", period_cnt, 400);
    chk("long_sw_est",     sw_est,     2);

    // period saturation: 20 high then 600 low -> period 1+19+600 saturates at 511
    for (int i = 1; i < 20; i++) tick(1'b1);
    for (int i = 0; i < 600; i++) tick(1'b0);
    chk("sat_stuck_lo", stuck_lo, 1);
    tick(1'b1);
    chk("sat_meas_valid", meas_valid, 1);
    chk("sat_high_cnt",   high_cnt,   20);
    chk("sat_period_cnt", period_cnt, 511);
    chk("sat_sw_est",     sw_est,     1);
    chk("sat_stuck_lo_clear", stuck_lo, 0);

    // reset mid-HIGH with valid outputs present, pulse stays high over reset
    for (int i = 0; i < 10; i++) tick(1'b1);
    rst = 1'b1;
    tick(1'b1);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1);
      strobes += int'(meas_valid);
    end
    for (int i = 0; i < 50; i++) begin
      tick(1'b0);
      strobes += int'(meas_valid);
    end
    chk("midrst_no_meas", strobes, 0);
    chk("midrst_state_idle", dut.state_q, IDLE);
    pwm_cycle(88, 256, 1'b0, 0, 0, 0);
    pwm_cycle(88, 256, 1'b1, 88, 256, 5);
    tick(1'b1);
    chk("final_meas_valid", meas_valid, 1);
    chk("final_high_cnt", high_cnt, 88);
    tick(1'b1);
    chk("final_strobe_one_cycle", meas_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
